// File: rtl/gb_alu_shift_arb.sv
// gb_alu_shift_arb: shared 64-bit shift unit (SLL/SRL/SRA plus RV64 word forms)
// that serves two issue ports. A round-robin arbiter picks the port, and the
// result goes into a one-entry registered buffer with a valid/ready handshake.
//
// Optional feature: when GB_SHIFT_ROR_EN is defined, op 2'b11 is rotate-right.
// When it is undefined, op 2'b11 is accepted and returns 0.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_reqN_valid/o_reqN_ready  request handshake for port N (N = 0, 1)
//   i_reqN_op             00 SLL, 01 SRL, 10 SRA, 11 ROR / zero
//   i_reqN_word           1 = 32-bit word op, result sign-extended
//   i_reqN_shamt          shift amount (bit 5 ignored for word ops)
//   i_reqN_src            64-bit operand
//   i_reqN_tag            opaque tag, returned with the result
//   o_res_valid/i_res_ready    result handshake
//   o_res_data, o_res_id, o_res_tag   result, winning port, and its tag
module gb_alu_shift_arb #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [1:0]       i_req0_op,
  input  logic             i_req0_word,
  input  logic [5:0]       i_req0_shamt,
  input  logic [63:0]      i_req0_src,
  input  logic [TAG_W-1:0] i_req0_tag,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [1:0]       i_req1_op,
  input  logic             i_req1_word,
  input  logic [5:0]       i_req1_shamt,
  input  logic [63:0]      i_req1_src,
  input  logic [TAG_W-1:0] i_req1_tag,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [63:0]      o_res_data,
  output logic             o_res_id,
  output logic [TAG_W-1:0] o_res_tag
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned WLEN = 32;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic             res_valid_q, res_valid_d;
  logic [XLEN-1:0]  res_data_q,  res_data_d;
  logic             res_id_q,    res_id_d;
  logic [TAG_W-1:0] res_tag_q,   res_tag_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept;
  logic             gnt_vld;
  logic             gnt_id;

  logic [1:0]       sel_op;
  logic             sel_word;
  logic [5:0]       sel_shamt;
  logic [XLEN-1:0]  sel_src;
  logic [TAG_W-1:0] sel_tag;

  logic [5:0]       sh_amt;
  logic [XLEN-1:0]  opnd;
  logic [XLEN-1:0]  shift_raw;
  logic [XLEN-1:0]  shift_res;
`ifdef GB_SHIFT_ROR_EN
  logic [2*XLEN-1:0] rot_dbl;
`endif

  // Round-robin arbitration; a new grant is possible only when the buffer is free or draining.
  always_comb begin
    can_accept = !res_valid_q || i_res_ready;
    gnt_vld    = 1'b0;
    gnt_id     = 1'b0;
    if (!i_rst && can_accept) begin
      if (i_req0_valid && i_req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (i_req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (i_req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    o_req0_ready = gnt_vld && !gnt_id;
    o_req1_ready = gnt_vld &&  gnt_id;
  end

  // Steer the winning port's payload onto the shared datapath.
  always_comb begin
    sel_op    = gnt_id ? i_req1_op    : i_req0_op;
    sel_word  = gnt_id ? i_req1_word  : i_req0_word;
    sel_shamt = gnt_id ? i_req1_shamt : i_req0_shamt;
    sel_src   = gnt_id ? i_req1_src   : i_req0_src;
    sel_tag   = gnt_id ? i_req1_tag   : i_req0_tag;
  end

  // Word ops are placed in a 64-bit frame whose upper half already holds the
  // fill pattern (sign for SRA, a copy of the word for ROR), so that a single
  // 64-bit shifter serves both widths.
  always_comb begin
    sh_amt = sel_word ? {1'b0, sel_shamt[4:0]} : sel_shamt;
    opnd   = sel_src;
    if (sel_word) begin
      case (sel_op)
        OP_SRA:  opnd = {{WLEN{sel_src[WLEN-1]}}, sel_src[WLEN-1:0]};
        OP_ROR:  opnd = {sel_src[WLEN-1:0], sel_src[WLEN-1:0]};
        default: opnd = {{WLEN{1'b0}}, sel_src[WLEN-1:0]};
      endcase
    end
  end

  // Shared shifter followed by word-result sign extension.
  always_comb begin
    shift_raw = '0;
`ifdef GB_SHIFT_ROR_EN
    rot_dbl   = '0;
`endif
    case (sel_op)
      OP_SLL:  shift_raw = opnd << sh_amt;
      OP_SRL:  shift_raw = opnd >> sh_amt;
      OP_SRA:  shift_raw = XLEN'($signed(opnd) >>> sh_amt);
      default: begin
`ifdef GB_SHIFT_ROR_EN
        rot_dbl   = {opnd, opnd} >> sh_amt;
        shift_raw = rot_dbl[XLEN-1:0];
`else
        shift_raw = '0;
`endif
      end
    endcase
    shift_res = sel_word ? {{WLEN{shift_raw[WLEN-1]}}, shift_raw[WLEN-1:0]} : shift_raw;
  end

  // The buffer loads on a grant and clears on a drain that has no replacement.
  always_comb begin
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    res_tag_d    = res_tag_q;
    last_grant_d = last_grant_q;
    if (gnt_vld) begin
      res_valid_d  = 1'b1;
      res_data_d   = shift_res;
      res_id_d     = gnt_id;
      res_tag_d    = sel_tag;
      last_grant_d = gnt_id;
    end else if (res_valid_q && i_res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers; last_grant resets to 1 so that port 0 wins the first contention.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      res_tag_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      res_tag_q    <= res_tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_res_valid = res_valid_q;
  assign o_res_data  = res_data_q;
  assign o_res_id    = res_id_q;
  assign o_res_tag   = res_tag_q;

endmodule

// File: doc/gb_alu_shift_arb.md
Name: gb_alu_shift_arb

Overview:
- Shares one 64-bit shift datapath (SLL/SRL/SRA, RV64 word ops) between two requesters: issue port 0 and issue port 1.
- Round-robin arbitration with valid/ready handshakes on both request ports.
- Operand conditioning: shamt masking, 32-bit word handling.
- One-entry registered result buffer with a valid/ready handshake toward writeback.

Parameters:
- TAG_W, 5, width of the opaque request tag returned with the result.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req0_valid  in  1  requester 0 has an operation.
- o_req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready.
- i_req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 rotate-right (see Optional Feature).
- i_req0_word  in  1  1 = 32-bit word op (SLLW/SRLW/SRAW).
- i_req0_shamt  in  6  shift amount.
- i_req0_src  in  64  operand.
- i_req0_tag  in  TAG_W  tag.
- i_req1_*  in  same as requester 0, for port 1.
- o_req1_ready  out  1  same as o_req0_ready, for port 1.
- o_res_valid  out  1  result buffer holds a result.
- i_res_ready  in  1  consumer accepts result when valid&ready.
- o_res_data  out  64  shift result.
- o_res_id  out  1  winning requester index.
- o_res_tag  out  TAG_W  tag of that request.

Behaviour:
- Handshake rules:
  - Requesters hold valid and payload stable until accepted.
  - Ready may depend combinationally on both valids.
- can_accept = !o_res_valid | i_res_ready.
- Arbitration, evaluated when can_accept:
  - Only one valid: grant it.
  - Both valid: grant the port not equal to last_grant.
  - Neither valid: no grant.
  - The granted port's ready=1; all other readies are 0.
  - When can_accept=0, both readies are 0.
- last_grant updates only on an accepted grant. Reset value 1, so req0 wins the first contention.
- Operand conditioning, 64-bit op (word=0):
  - Effective shamt = shamt[5:0].
  - SRA fills with src[63].
  - SRL and SLL fill with 0.
- Operand conditioning, word op (word=1):
  - Operand is src[31:0].
  - Effective shamt = shamt[4:0]; shamt[5] is ignored.
  - SRA fills with src[31]; SRL fills with 0.
  - The 32-bit result is sign-extended from its bit 31 to 64 bits, for all ops.
- Shift amount 0: result = conditioned operand (sign-extended for word ops).
- Latency: fixed 1 cycle.
  - A request accepted in cycle N has o_res_valid=1 with data/id/tag in cycle N+1.
  - Throughput is 1 per cycle while i_res_ready=1.
- Result buffer:
  - Loaded on grant.
  - Cleared (o_res_valid=0) on valid&ready with no new grant.
  - Simultaneous drain and grant: the buffer reloads and o_res_valid stays 1.
  - With o_res_valid=1 and i_res_ready=0, the buffer holds and outputs stay stable.
- Reset values:
  - o_res_valid=0; o_res_data=0; o_res_id=0; o_res_tag=0; last_grant=1.
  - o_req0_ready and o_req1_ready are 0 during i_rst.
- Reset mid-operation: any buffered result is discarded and no grant occurs in the reset cycle.
- Op 11 without the Optional Feature:
  - Accepted normally.
  - Result 0.
  - No error signalled.

Optional Feature:
- Macro: GB_SHIFT_ROR_EN.
- Defined: op 11 = rotate right.
  - 64-bit op: rotate by shamt[5:0].
  - Word op: rotate src[31:0] by shamt[4:0], then sign-extend the result from bit 31.
- Undefined: op 11 returns 0 and no rotate logic is instantiated.

Test Plan:
- Reset then req0 SRA, word=0, src=0x8000_0000_0000_0000, shamt=4, tag=3 -> next cycle o_res_valid=1, data=0xF800_0000_0000_0000, id=0, tag=3.
- req1 SRAW, src=0x0000_0000_8000_00F0, shamt=4 -> data=0xFFFF_FFFF_F800_000F. Repeat with shamt=36 -> same result, since shamt[5] is ignored.
- Both valid for 4 consecutive cycles, i_res_ready=1 -> grants 0,1,0,1; one result per cycle; tags match.
- o_res_valid=1, i_res_ready=0 for 3 cycles with both requesters valid -> both readies 0, outputs stable. Then i_res_ready=1 -> drain and reload in the same cycle; o_res_valid stays 1.
- i_rst asserted with a buffered result and pending requests -> o_res_valid=0 next cycle; after release, req0 wins first contention.
- GB_SHIFT_ROR_EN defined: op 11, word=0, src=0x1, shamt=1 -> 0x8000_0000_0000_0000. Undefined: same stimulus -> 0.
